// File: rtl/psum_acc_pkg.sv
// Shared types and arithmetic for the partial-sum accumulator.
//   acc_state_t : controller states (IDLE, RUN, DONE)
//   SUM_W       : internal working width for the widened adder
//   sat_add()   : signed add with overflow detect and optional clamp
package psum_acc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} acc_state_t;

    // Working width for the adder. Any OUT_W below this gets at least one
    // guard bit, so the raw sum never wraps before the range check.
    localparam int SUM_W = 64;

    typedef struct packed {
        logic             ovf;
        logic [SUM_W-1:0] sum;
    } add_res_t;

    // a and b must already be sign-extended values inside the signed w-bit range.
    // ovf flags any result outside that range. With sat_en the result is
    // clamped; otherwise the caller keeps the low w bits (two's-complement wrap).
    function automatic add_res_t sat_add(
        input logic signed [SUM_W-1:0] a,
        input logic signed [SUM_W-1:0] b,
        input int                      w,
        input logic                    sat_en
    );
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        add_res_t                r;
        s  = a + b;
        hi = {{(SUM_W-1){1'b0}}, 1'b1};
        hi = (hi <<< (w - 1)) - hi;   // +2^(w-1)-1
        lo = ~hi;                     // -2^(w-1)
        r.ovf = (s > hi) || (s < lo);
        r.sum = s;
        if (sat_en && (s > hi)) begin
            r.sum = hi;
        end else if (sat_en && (s < lo)) begin
            r.sum = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_acc_multi_lane.sv
// acc_lane: one accumulator lane (register, adder, sticky overflow flag).
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear of acc and flag
//   ld         : seed from i_psum (combined with add when both are high)
//   add        : accumulate i_prod (on top of the seed when ld is high)
//   i_psum     : signed seed, OUT_W bits
//   i_prod     : signed product, IN_W bits
//   o_acc      : accumulator value
//   o_sat      : sticky overflow flag, cleared by a seed
module acc_lane
    import psum_acc_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             add,
    input  logic [OUT_W-1:0] i_psum,
    input  logic [IN_W-1:0]  i_prod,
    output logic [OUT_W-1:0] o_acc,
    output logic             o_sat
);

    logic [OUT_W-1:0]        acc_reg;
    logic                    sat_reg;
    logic [OUT_W-1:0]        base;
    logic signed [SUM_W-1:0] base_ext;
    logic signed [SUM_W-1:0] prod_ext;
    add_res_t                res;
    logic                    unused_hi;

    // A seed and a first term can arrive together, so the adder operand is
    // the incoming seed whenever ld is high.
    always_comb begin
        base     = ld ? i_psum : acc_reg;
        base_ext = {{(SUM_W-OUT_W){base[OUT_W-1]}}, base};
        prod_ext = {{(SUM_W-IN_W){i_prod[IN_W-1]}}, i_prod};
        res      = sat_add(base_ext, prod_ext, OUT_W, SAT != 0);
    end

    assign unused_hi = ^res.sum[SUM_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
            sat_reg <= 1'b0;
        end else if (clr) begin
            acc_reg <= '0;
            sat_reg <= 1'b0;
        end else if (add) begin
            acc_reg <= res.sum[OUT_W-1:0];
            // A seed starts a fresh job: only this cycle's overflow survives.
            sat_reg <= (ld ? 1'b0 : sat_reg) | res.ovf;
        end else if (ld) begin
            acc_reg <= i_psum;
            sat_reg <= 1'b0;
        end
    end

    assign o_acc = acc_reg;
    assign o_sat = sat_reg;

endmodule

// File: rtl/psum_acc_multi.sv
// psum_acc_multi: NUM_CH-lane partial-sum accumulator with a shared
// length counter and IDLE/RUN/DONE controller.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear / job abort
//   start      : accept a job (in IDLE or DONE), seeds lanes from i_psum
//   en         : one product term per cycle is consumed when high
//   i_len      : term count, 0 treated as 1, sampled on accepted start
//   i_psum     : seeds, lane k at [k*OUT_W +: OUT_W]
//   i_prod     : products, lane k at [k*IN_W +: IN_W]
//   o_data     : accumulator registers
//   o_valid    : one-cycle pulse, o_data holds a finished result
//   o_busy     : high while in RUN
//   o_sat      : per-lane sticky overflow flags for the current job
module psum_acc_multi
    import psum_acc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int LEN_W  = 8,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    en,
    input  logic [LEN_W-1:0]        i_len,
    input  logic [NUM_CH*OUT_W-1:0] i_psum,
    input  logic [NUM_CH*IN_W-1:0]  i_prod,
    output logic [NUM_CH*OUT_W-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic [NUM_CH-1:0]       o_sat
);

    acc_state_t       state_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [LEN_W-1:0] len_q_reg;
    logic             valid_reg;
    logic             busy_reg;

    logic             accept;
    logic             lane_add;
    logic [LEN_W-1:0] len_new;
    logic [LEN_W-1:0] cnt_inc;

    // DONE accepts a new job just like IDLE so jobs can run back to back.
    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign lane_add = en && (accept || (state_reg == RUN));
    assign len_new  = (i_len == '0) ? LEN_W'(1) : i_len;
    assign cnt_inc  = cnt_reg + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            len_q_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (clr) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        len_q_reg <= len_new;
                        if (en) begin
                            cnt_reg <= LEN_W'(1);
                            if (len_new == LEN_W'(1)) begin
                                state_reg <= DONE;
                                valid_reg <= 1'b1;
                            end else begin
                                state_reg <= RUN;
                                busy_reg  <= 1'b1;
                            end
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    busy_reg <= 1'b1;
                    if (en) begin
                        cnt_reg <= cnt_inc;
                        if (cnt_inc == len_q_reg) begin
                            state_reg <= DONE;
                            valid_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            acc_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W),
                .SAT   (SAT)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr),
                .ld     (accept),
                .add    (lane_add),
                .i_psum (i_psum[gi*OUT_W +: OUT_W]),
                .i_prod (i_prod[gi*IN_W +: IN_W]),
                .o_acc  (o_data[gi*OUT_W +: OUT_W]),
                .o_sat  (o_sat[gi])
            );
        end
    endgenerate

    assign o_valid = valid_reg;
    assign o_busy  = busy_reg;

endmodule

// File: tb/tb_psum_acc_multi.sv
module tb_psum_acc_multi;

    localparam int NUM_CH = 4;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int LEN_W  = 8;

    typedef struct packed {
        logic [NUM_CH*OUT_W-1:0] data;
        logic [NUM_CH-1:0]       sat;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clr;
    logic                    start;
    logic                    en;
    logic [LEN_W-1:0]        i_len;
    logic [NUM_CH*OUT_W-1:0] i_psum;
    logic [NUM_CH*IN_W-1:0]  i_prod;
    logic [NUM_CH*OUT_W-1:0] o_data;
    logic                    o_valid;
    logic                    o_busy;
    logic [NUM_CH-1:0]       o_sat;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    psum_acc_multi #(
        .NUM_CH (NUM_CH),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .LEN_W  (LEN_W),
        .SAT    (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .start   (start),
        .en      (en),
        .i_len   (i_len),
        .i_psum  (i_psum),
        .i_prod  (i_prod),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_sat   (o_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [NUM_CH*OUT_W-1:0] act,
                       input logic [NUM_CH*OUT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*OUT_W-1:0] all4(input logic [OUT_W-1:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [NUM_CH*IN_W-1:0] allp(input logic [IN_W-1:0] v);
        return {v, v, v, v};
    endfunction

    task automatic push(input logic [NUM_CH*OUT_W-1:0] d, input logic [NUM_CH-1:0] s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        sb_q.push_back(e);
    endtask

    // Monitor: every o_valid pulse must match the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (o_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_valid act=%h exp=none", o_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn result data=%h sat=%b exp_data=%h exp_sat=%b",
                         o_data, o_sat, e.data, e.sat);
                total++;
                if (o_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_data act=%h exp=%h", o_data, e.data);
                end
                total++;
                if (o_sat !== e.sat) begin
                    bad++;
                    $display("FAIL sb_sat act=%b exp=%b", o_sat, e.sat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        start  = 1'b0;
        en     = 1'b0;
        i_len  = '0;
        i_psum = '0;
        i_prod = '0;
        tick();
        tick();
        chk("rst_data", o_data, '0);
        chk("rst_ctl", {o_valid, o_busy, o_sat}, '0);

        // Basic job: len 3, seed 100, products 5,6,7 -> 118
        rst_n  = 1'b1;
        push(all4(32'd118), 4'b0000);
        start  = 1'b1; en = 1'b1; i_len = 8'd3;
        i_psum = all4(32'd100); i_prod = allp(16'd5);
        tick();
        chk("basic_busy1", {o_busy, o_valid}, 2'b10);
        start  = 1'b0; i_prod = allp(16'd6);
        tick();
        chk("basic_busy2", {o_busy, o_valid}, 2'b10);
        i_prod = allp(16'd7);
        tick();
        chk("basic_valid", {o_busy, o_valid}, 2'b01);
        en = 1'b0;
        tick();
        chk("basic_after", {o_busy, o_valid}, 2'b00);
        chk("basic_hold", o_data, all4(32'd118));

        // rst_n pulsed low between edges must not change anything
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_no_edge", o_data, all4(32'd118));

        // Reset mid-RUN
        start = 1'b1; en = 1'b1; i_len = 8'd4;
        i_psum = all4(32'd9); i_prod = allp(16'd1);
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0; en = 1'b0;
        tick();
        tick();
        chk("midrun_rst_data", o_data, '0);
        chk("midrun_rst_ctl", {o_valid, o_busy, o_sat}, '0);
        rst_n = 1'b1;

        // Bubbles: len 2, en 1,0,0,1; a start during RUN is ignored
        push({32'd3991, 32'd2991, 32'd1991, 32'd991}, 4'b0000);
        start = 1'b1; en = 1'b1; i_len = 8'd2;
        i_psum = {32'd4000, 32'd3000, 32'd2000, 32'd1000};
        i_prod = {16'd4, 16'd3, 16'd2, 16'd1};
        tick();
        chk("bub_c1", {o_busy, o_valid}, 2'b10);
        start = 1'b1; en = 1'b0; i_len = 8'd5; i_psum = '0;
        tick();
        chk("bub_c2", {o_busy, o_valid}, 2'b10);
        start = 1'b0;
        tick();
        chk("bub_c3", {o_busy, o_valid}, 2'b10);
        en = 1'b1;
        i_prod = {16'hFFF3, 16'hFFF4, 16'hFFF5, 16'hFFF6};
        tick();
        chk("bub_valid", {o_busy, o_valid}, 2'b01);
        en = 1'b0;
        tick();

        // Saturation, len 2: lane0 clamps high then moves off the rail
        // (flag stays), lane1 clamps low, lanes 2/3 stay in range.
        push({32'hFFFF_FFF9, 32'd13, 32'h8000_0000, 32'h7FFF_FFFE}, 4'b0011);
        start = 1'b1; en = 1'b1; i_len = 8'd2;
        i_psum = {32'hFFFF_FFFB, 32'd10, 32'h8000_0005, 32'h7FFF_FFF0};
        i_prod = {16'hFFFE, 16'd3, 16'hFFF0, 16'h0020};
        tick();
        chk("sat_first", o_data, {32'hFFFF_FFF9, 32'd13, 32'h8000_0000, 32'h7FFF_FFFF});
        chk("sat_flags1", {28'd0, o_sat}, {28'd0, 4'b0011});
        start = 1'b0;
        i_prod = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        tick();
        chk("sat_valid", {o_busy, o_valid}, 2'b01);

        // Back-to-back from DONE with i_len=0 (acts as length 1)
        push(all4(32'd51), 4'b0000);
        start = 1'b1; en = 1'b1; i_len = 8'd0;
        i_psum = all4(32'd50); i_prod = allp(16'd1);
        tick();
        chk("b2b_valid", {o_busy, o_valid}, 2'b01);
        start = 1'b0; en = 1'b0;
        tick();
        chk("b2b_idle", {o_busy, o_valid}, 2'b00);

        // clr mid-RUN (cnt=1 of 4), then a normal job
        start = 1'b1; en = 1'b1; i_len = 8'd4;
        i_psum = all4(32'd7); i_prod = allp(16'd1);
        tick();
        start = 1'b0; en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_data", o_data, '0);
        chk("clr_ctl", {o_valid, o_busy, o_sat}, '0);
        en = 1'b1;
        tick();
        tick();
        chk("clr_stays_idle", {o_busy, o_valid}, 2'b00);
        push(all4(32'd25), 4'b0000);
        start = 1'b1; en = 1'b1; i_len = 8'd2;
        i_psum = all4(32'd20); i_prod = allp(16'd2);
        tick();
        start = 1'b0; i_prod = allp(16'd3);
        tick();
        chk("post_clr_valid", {o_busy, o_valid}, 2'b01);
        en = 1'b0;
        tick();
        tick();

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_pending act=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
